tt_sel_seq: RTL and testbench
=============================

Name: tt_sel_seq

Overview:
- Design-select sequencer driving the three chip control pins (sel_rst_n, sel_inc, ena) that the top level routes to the mux controller.
- Takes an address request from a management/test host and emits the reset / increment-pulse / enable waveform that selects the user design.
- Tracks the currently selected address. A forward move is done by incremental pulsing, with no reset.

Parameters:
ADDR_W, 10, width of design address / increment counter
PULSE_W, 2, cycles sel_inc stays high, and cycles it stays low, per increment; also release hold after reset
RST_W, 4, cycles sel_rst_n held low during a full reselect
GAP_W, 2, cycles ena held low before any selection activity
MAX_ADDR, 1023, highest legal address; must be <= 2**ADDR_W-1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  select request valid
req_ready  out  1  sequencer idle, request accepted when valid&ready at posedge
req_addr  in  ADDR_W  target design address
req_ena  in  1  value of ctrl_ena once selection completes
done  out  1  one-cycle pulse, selection finished
err  out  1  one-cycle pulse, request rejected (addr > MAX_ADDR)
busy  out  1  high from accept until done/err
cur_addr  out  ADDR_W  currently selected address
cur_valid  out  1  cur_addr is meaningful
ctrl_sel_rst_n  out  1  to pad_ch[4], selection counter reset, active-low
ctrl_sel_inc  out  1  to pad_ch[2], selection increment
ctrl_ena  out  1  to pad_ch[0], design enable

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered. No combinational path from req_* to any output.
- Reset values:
  - state=IDLE, req_ready=0, busy=0, done=0, err=0.
  - cur_addr=0, cur_valid=0.
  - ctrl_sel_rst_n=0, ctrl_sel_inc=0, ctrl_ena=0.
  - req_ready rises on the first clk edge after rst deasserts.
- Accept: at a posedge with req_valid&req_ready, latch addr and ena, req_ready<=0, busy<=1. Requests while busy are ignored.
- Illegal address: if req_addr>MAX_ADDR, the next cycle gives err=1, busy=0, req_ready=1. No pin changes; cur_* unchanged.
- FSM states: IDLE -> DIS -> (RST -> REL)? -> INC_H/INC_L loop -> FIN -> IDLE.
- DIS: ctrl_ena=0 for GAP_W cycles. Then compute n:
  - If cur_valid && addr>=cur_addr: n=addr-cur_addr, skip RST/REL.
  - Otherwise go to RST with n=addr.
- RST: ctrl_sel_rst_n=0 for RST_W cycles.
- REL: ctrl_sel_rst_n=1 for PULSE_W cycles.
- INC_H / INC_L: ctrl_sel_inc=1 for PULSE_W cycles, then 0 for PULSE_W cycles; repeat n times. If n=0, go straight to FIN.
- FIN (1 cycle):
  - ctrl_ena<=req_ena, cur_addr<=addr, cur_valid<=1, done=1.
  - busy<=0, req_ready<=1 next cycle.
- Latency, accept edge to done cycle:
  - Full path: GAP_W+RST_W+PULSE_W+2*PULSE_W*n+1 cycles.
  - Incremental path: GAP_W+2*PULSE_W*n+1 cycles.
- ctrl_sel_inc is low whenever ctrl_sel_rst_n is low.
- ctrl_sel_rst_n stays 1 outside RST once the first selection completes.
- Same-address request: ena still drops for GAP_W cycles, with zero pulses.
- addr=0 on full path: reset/release only, zero pulses.
- Backward move (addr<cur_addr): always full path.
- Counter widths:
  - Pulse counter is ADDR_W bits. Subtraction is done only when addr>=cur_addr, so no wrap.
  - Timer sized for max(PULSE_W,RST_W,GAP_W).
- Reset mid-operation: all state and pins return to reset values immediately and cur_valid=0. The next request therefore takes the full path.
- err and done are never asserted in the same cycle.

Test Plan:
- Reset release, then req addr=3 ena=1 (defaults):
  - sel_rst_n low 4 cycles, 3 inc pulses of 2 high/2 low.
  - done at cycle 21 after accept.
  - ctrl_ena=1, cur_addr=3, cur_valid=1.
- From cur_addr=3, req addr=5:
  - No sel_rst_n low.
  - ena low 2 cycles, 2 pulses, done at cycle 11, cur_addr=5.
- From cur_addr=5, req addr=2 ena=0:
  - Full path with 2 pulses, done at cycle 17, ctrl_ena stays 0.
- req addr=5 with MAX_ADDR=4:
  - err pulse 1 cycle after accept, no pin toggles, cur_addr unchanged, req_ready=1 next cycle.
- Hold req_valid with a second addr while busy: ignored until req_ready=1, then accepted. Same-addr request gives done at cycle 3 with 0 pulses.
- Assert rst during the INC_H of the 2nd pulse:
  - Pins go 0/0/0 asynchronously, cur_valid=0.
  - Next req addr=1 takes the full path with sel_rst_n low 4 cycles.

Source files
------------

// File: rtl/tt_sel_seq.sv
// tt_sel_seq: design-select sequencer for the mux controller pins.
// Accepts an address request and drives the reset / increment-pulse /
// enable waveform on ctrl_sel_rst_n, ctrl_sel_inc and ctrl_ena. It tracks
// the selected address, so a forward move is done by pulsing only.
// Ports:
//   clk, rst                     clock, async active-high reset
//   req_valid/req_ready          request handshake (accept on valid&ready)
//   req_addr, req_ena            target address, final ctrl_ena value
//   done, err                    one-cycle completion / rejection pulses
//   busy                         high from accept until done/err
//   cur_addr, cur_valid          currently selected address
//   ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena   chip control pins
module tt_sel_seq #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned PULSE_W  = 2,
  parameter int unsigned RST_W    = 4,
  parameter int unsigned GAP_W    = 2,
  parameter int unsigned MAX_ADDR = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  localparam int unsigned TMR_MAX =
    (PULSE_W > RST_W) ? ((PULSE_W > GAP_W) ? PULSE_W : GAP_W)
                      : ((RST_W > GAP_W) ? RST_W : GAP_W);
  localparam int unsigned TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [ADDR_W:0] MAX_EXT = (ADDR_W+1)'(MAX_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_DIS, S_RST, S_REL, S_INC_H, S_INC_L, S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rena_q, rena_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              cur_valid_q, cur_valid_d;
  logic              rstn_q, rstn_d;
  logic              inc_q, inc_d;
  logic              ena_q, ena_d;

  // Request decode and forward-move distance (only used when addr >= cur).
  logic              addr_bad;
  logic              fwd;
  logic [ADDR_W-1:0] diff;
  logic              tmr_zero;

  assign addr_bad = {1'b0, req_addr} > MAX_EXT;
  assign fwd      = cur_valid_q && (addr_q >= cur_addr_q);
  assign diff     = addr_q - cur_addr_q;
  assign tmr_zero = (timer_q == '0);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      rena_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cur_addr_q  <= '0;
      cur_valid_q <= 1'b0;
      rstn_q      <= 1'b0;
      inc_q       <= 1'b0;
      ena_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rena_q      <= rena_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cur_addr_q  <= cur_addr_d;
      cur_valid_q <= cur_valid_d;
      rstn_q      <= rstn_d;
      inc_q       <= inc_d;
      ena_q       <= ena_d;
    end
  end

  // Next-state and next-output logic; pin registers follow the next state.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rena_d      = rena_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cur_addr_d  = cur_addr_q;
    cur_valid_d = cur_valid_q;
    rstn_d      = rstn_q;
    inc_d       = 1'b0;
    ena_d       = ena_q;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          addr_d  = req_addr;
          rena_d  = req_ena;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (addr_bad) begin
            state_d = S_ERR;
          end else begin
            // Release the select reset left asserted by a chip reset so
            // the full path shows one clean low pulse.
            state_d = S_DIS;
            timer_d = TMR_W'(GAP_W - 1);
            ena_d   = 1'b0;
            rstn_d  = 1'b1;
          end
        end
      end

      S_ERR: begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end

      S_DIS: begin
        if (!tmr_zero) begin
          timer_d = timer_q - TMR_W'(1);
        end else if (fwd) begin
          cnt_d = diff;
          if (diff == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_INC_H;
            timer_d = TMR_W'(PULSE_W - 1);
            inc_d   = 1'b1;
          end
        end else begin
          state_d = S_RST;
          timer_d = TMR_W'(RST_W - 1);
          cnt_d   = addr_q;
          rstn_d  = 1'b0;
        end
      end

      S_RST: begin
        if (!tmr_zero) begin
          timer_d = timer_q - TMR_W'(1);
        end else begin
          state_d = S_REL;
          timer_d = TMR_W'(PULSE_W - 1);
          rstn_d  = 1'b1;
        end
      end

      S_REL: begin
        if (!tmr_zero) begin
          timer_d = timer_q - TMR_W'(1);
        end else if (cnt_q == '0) begin
          state_d = S_FIN;
        end else begin
          state_d = S_INC_H;
          timer_d = TMR_W'(PULSE_W - 1);
          inc_d   = 1'b1;
        end
      end

      S_INC_H: begin
        if (!tmr_zero) begin
          timer_d = timer_q - TMR_W'(1);
          inc_d   = 1'b1;
        end else begin
          state_d = S_INC_L;
          timer_d = TMR_W'(PULSE_W - 1);
        end
      end

      S_INC_L: begin
        if (!tmr_zero) begin
          timer_d = timer_q - TMR_W'(1);
        end else begin
          cnt_d = cnt_q - ADDR_W'(1);
          if (cnt_q == ADDR_W'(1)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_INC_H;
            timer_d = TMR_W'(PULSE_W - 1);
            inc_d   = 1'b1;
          end
        end
      end

      S_FIN: begin
        state_d     = S_IDLE;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        ready_d     = 1'b1;
        ena_d       = rena_q;
        cur_addr_d  = addr_q;
        cur_valid_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready      = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign cur_addr       = cur_addr_q;
  assign cur_valid      = cur_valid_q;
  assign ctrl_sel_rst_n = rstn_q;
  assign ctrl_sel_inc   = inc_q;
  assign ctrl_ena       = ena_q;

endmodule

// File: tb/tb_tt_sel_seq.sv
// Testbench for tt_sel_seq: table of select requests with hand-computed
// latency / pulse / reset-width expectations, plus directed sequences for
// request-while-busy, illegal address and reset in mid-operation.
module tb_tt_sel_seq;

  logic       clk = 1'b0;
  logic       rst;

  logic       req_valid, req_ready, req_ena;
  logic [9:0] req_addr;
  logic       done, err, busy, cur_valid;
  logic [9:0] cur_addr;
  logic       ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;

  logic       m_valid, m_ready, m_ena_in;
  logic [9:0] m_addr;
  logic       m_done, m_err, m_busy, m_cur_valid;
  logic [9:0] m_cur_addr;
  logic       m_rstn, m_inc, m_ena;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  tt_sel_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_ena(req_ena),
    .done(done), .err(err), .busy(busy), .cur_addr(cur_addr), .cur_valid(cur_valid),
    .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena)
  );

  tt_sel_seq #(.MAX_ADDR(4)) dut_m (
    .clk(clk), .rst(rst),
    .req_valid(m_valid), .req_ready(m_ready), .req_addr(m_addr), .req_ena(m_ena_in),
    .done(m_done), .err(m_err), .busy(m_busy), .cur_addr(m_cur_addr), .cur_valid(m_cur_valid),
    .ctrl_sel_rst_n(m_rstn), .ctrl_sel_inc(m_inc), .ctrl_ena(m_ena)
  );

  typedef struct {
    logic [9:0] addr;
    logic       ena;
    int         exp_lat;
    int         exp_pulses;
    int         exp_rstlow;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Apply one request to dut and measure the waveform up to done.
  task automatic do_vec(input int idx, input vec_t v);
    int lat, rl, pulses, inc_hi, guard;
    bit prev_inc, inv_bad, ena_bad, busy_bad;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("v%0d_ready", idx), int'(req_ready), 1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_ena   = v.ena;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0; rl = 0; pulses = 0; inc_hi = 0;
    prev_inc = 1'b0; inv_bad = 1'b0; ena_bad = 1'b0; busy_bad = 1'b0;
    while (!done && lat < 6000) begin
      if (!ctrl_sel_rst_n) rl++;
      if (ctrl_sel_inc) inc_hi++;
      if (ctrl_sel_inc && !prev_inc) pulses++;
      prev_inc = ctrl_sel_inc;
      if (ctrl_sel_inc && !ctrl_sel_rst_n) inv_bad = 1'b1;
      if (ctrl_ena) ena_bad = 1'b1;
      if (!busy || req_ready || err) busy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_pulses", idx), pulses, v.exp_pulses);
    chk($sformatf("v%0d_inc_high_cycles", idx), inc_hi, 4 * v.exp_pulses / 2);
    chk($sformatf("v%0d_rst_low_cycles", idx), rl, v.exp_rstlow);
    chk($sformatf("v%0d_cur_addr", idx), int'(cur_addr), int'(v.addr));
    chk($sformatf("v%0d_cur_valid", idx), int'(cur_valid), 1);
    chk($sformatf("v%0d_ctrl_ena", idx), int'(ctrl_ena), int'(v.ena));
    chk($sformatf("v%0d_done_state", idx),
        int'({busy, req_ready, err, ctrl_sel_rst_n, ctrl_sel_inc}), int'(5'b01010));
    chk($sformatf("v%0d_inc_during_rst", idx), int'(inv_bad), 0);
    chk($sformatf("v%0d_ena_low_while_busy", idx), int'(ena_bad), 0);
    chk($sformatf("v%0d_busy_window", idx), int'(busy_bad), 0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_done_one_cycle", idx), int'(done), 0);
  endtask

  // Apply one request to dut_m; report cycles to done/err and pin movement.
  task automatic m_req(input logic [9:0] a, input logic e,
                       output int lat, output bit got_err, output bit pin_chg);
    logic [2:0] pins0;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!m_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    pins0 = {m_rstn, m_inc, m_ena};
    m_valid  = 1'b1;
    m_addr   = a;
    m_ena_in = e;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    lat = 0;
    pin_chg = 1'b0;
    while (!m_done && !m_err && lat < 500) begin
      if ({m_rstn, m_inc, m_ena} != pins0) pin_chg = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if ({m_rstn, m_inc, m_ena} != pins0) pin_chg = 1'b1;
    got_err = m_err;
  endtask

  vec_t vecs[9];

  initial begin
    int  lat, k;
    bit  ge, pc;
    bit  first_done_seen;

    // addr, ena, latency, pulses, sel_rst_n low cycles
    vecs[0] = '{10'd3,    1'b1, 21,   3,    4};  // first select, full path
    vecs[1] = '{10'd5,    1'b1, 11,   2,    0};  // forward, incremental
    vecs[2] = '{10'd2,    1'b0, 17,   2,    4};  // backward, full path
    vecs[3] = '{10'd2,    1'b1, 3,    0,    0};  // same address
    vecs[4] = '{10'd0,    1'b1, 9,    0,    4};  // addr 0, reset/release only
    vecs[5] = '{10'd1,    1'b0, 7,    1,    0};  // single pulse
    vecs[6] = '{10'd1023, 1'b1, 4091, 1022, 0};  // up to the top address
    vecs[7] = '{10'd1022, 1'b1, 4097, 1022, 4};  // one step back
    vecs[8] = '{10'd1,    1'b1, 13,   1,    4};  // after mid-op reset

    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_ena = 1'b0;
    m_valid = 1'b0; m_addr = '0; m_ena_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        int'({req_ready, busy, done, err, cur_valid, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena}), 0);
    chk("reset_cur_addr", int'(cur_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_before_first_edge", int'(req_ready), 0);
    @(posedge clk);
    #1;
    chk("ready_after_first_edge", int'(req_ready), 1);

    // Illegal address on the MAX_ADDR=4 instance before any selection.
    m_req(10'd5, 1'b1, lat, ge, pc);
    chk("m_err_latency", lat, 1);
    chk("m_err_flag", int'(ge), 1);
    chk("m_err_pins_still", int'(pc), 0);
    chk("m_err_cycle_state", int'({m_busy, m_ready, m_done, m_cur_valid}), int'(4'b0100));
    @(posedge clk);
    #1;
    chk("m_err_one_cycle", int'(m_err), 0);
    // Boundary-legal address: full path, 4 pulses.
    m_req(10'd4, 1'b1, lat, ge, pc);
    chk("m_max_latency", lat, 25);
    chk("m_max_no_err", int'(ge), 0);
    chk("m_max_cur_addr", int'(m_cur_addr), 4);
    // Illegal address with a selection in place leaves everything alone.
    m_req(10'd5, 1'b0, lat, ge, pc);
    chk("m_err2_latency", lat, 1);
    chk("m_err2_flag", int'(ge), 1);
    chk("m_err2_pins_still", int'(pc), 0);
    chk("m_err2_cur", int'({m_cur_addr, m_cur_valid, m_ena, m_rstn}), int'({10'd4, 3'b111}));

    for (int i = 0; i < 8; i++) do_vec(i, vecs[i]);

    // Hold req_valid while busy with a different address: first request
    // (same address, 0 pulses) must finish untouched, then the second one.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 10'd1022; req_ena = 1'b1;
    @(posedge clk);
    #1;
    req_addr = 10'd1023;
    first_done_seen = 1'b0;
    k = 0;
    while (!done && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("hold_first_done_cycle", k, 3);
    chk("hold_first_cur_addr", int'(cur_addr), 1022);
    chk("hold_ready_at_done", int'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    k++;
    chk("hold_second_accepted", int'({busy, req_ready}), int'(2'b10));
    while (!done && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("hold_second_done_cycle", k, 11);
    chk("hold_second_cur_addr", int'(cur_addr), 1023);

    // Reset during the high phase of the second pulse of a full-path move.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 10'd10; req_ena = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
    end
    chk("midrst_in_pulse2_high", int'({ctrl_sel_rst_n, ctrl_sel_inc, busy}), int'(3'b111));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_pins_async",
        int'({ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, cur_valid, busy, req_ready}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_vec(8, vecs[8]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Watchdog so the bench always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
